ahb_timer: RTL and testbench
============================

Name: ahb_timer

Overview:
- AHB-Lite slave timer: 32-bit up-counter with prescaler, compare match and a level interrupt.
- Drives the core's `timer_irq_i` input in the SoC top.
- Occupies one slave slot on the AHB interconnect; reuses the `HADDR_BUS`/`HDATA_BUS` widths from defines.v.
- Zero-wait-state for legal accesses; two-cycle ERROR response for illegal ones.

Parameters:
- PRESC_W, 16, width of the prescaler register and prescaler counter.
- ADDR_LSB_W, 5, number of low haddr bits decoded (register window 32 bytes).

Ports:
- clk  in  1  system clock (also HCLK).
- rst  in  1  synchronous reset, active-high.
- hsel_i  in  1  slave select from the interconnect.
- hwrite_i  in  1  1 = write transfer.
- hready_i  in  1  bus HREADY; an address phase is accepted only when this is high.
- hsize_i  in  3  transfer size.
- hburst_i  in  3  burst type; ignored.
- htrans_i  in  2  transfer type.
- hwdata_i  in  32  write data (data phase).
- haddr_i  in  32  address (address phase).
- hreadyout_o  out  1  slave ready.
- hresp_o  out  1  0 = OKAY, 1 = ERROR.
- hrdata_o  out  32  read data.
- timer_irq_o  out  1  level interrupt, connects to the core's `timer_irq_i`.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all registers 0, `hreadyout_o` = 1, `hresp_o` = 0, `hrdata_o` = 0, `timer_irq_o` = 0.
- Register map (offset = `haddr_i[4:2]` × 4):
  - 0x00 CTRL: [0] EN, [1] IE, [2] AUTORELOAD; other bits read 0.
  - 0x04 COUNT: rw.
  - 0x08 CMP: rw.
  - 0x0C STATUS: [0] PEND; write 1 to clear, write 0 has no effect.
  - 0x10 PRESC: rw, width PRESC_W, zero-extended on read.
  - 0x14–0x1C: reserved; read 0, writes ignored, OKAY response.
- Address phase accept: `hsel_i & hready_i & htrans_i[1]`. IDLE/BUSY transfers are ignored and get an OKAY response.
  - On accept, latch write flag, register index and a legality flag.
  - Legal = `hsize_i` == 3'b010 and `haddr_i[1:0]` == 0.
- Legal write: register updated at the end of the data phase from `hwdata_i`. Back-to-back transfers are supported.
- Legal read: `hrdata_o` is registered at the address-phase accept and is valid throughout the data phase with `hreadyout_o` = 1. Latency = 0 wait states.
- Response FSM:
  - States: OKAY, ERR1, ERR2.
  - OKAY → ERR1 on accept of an illegal transfer.
  - ERR1: `hreadyout_o` = 0, `hresp_o` = 1.
  - ERR1 → ERR2.
  - ERR2: `hreadyout_o` = 1, `hresp_o` = 1.
  - ERR2 → OKAY, or → ERR1 if another illegal transfer is accepted in ERR2.
  - Illegal transfers never modify registers.
- Prescaler: when EN = 1, `pcnt` increments each cycle.
  - When `pcnt` == PRESC: `tick` = 1 and `pcnt` ← 0.
  - PRESC = 0 gives a tick every cycle.
  - When EN = 0, `pcnt` is held at 0.
- Counter, on tick:
  - If COUNT == CMP: PEND ← 1, and COUNT ← (AUTORELOAD ? 0 : COUNT+1).
  - Otherwise COUNT ← COUNT+1.
  - Arithmetic is modulo 2^32 (0xFFFFFFFF wraps to 0).
- Simultaneous events:
  - Bus write to COUNT and tick in the same cycle: the bus write wins and the increment is lost.
  - Write-1 to STATUS and match-set in the same cycle: set wins, PEND stays 1.
  - Write to PRESC resets `pcnt` to 0.
- Interrupt: `timer_irq_o` = PEND & IE, driven from registers (no combinational path from the bus). It stays asserted until PEND is cleared or IE is cleared.
- Reset mid-transfer: FSM returns to OKAY; any pending error or write is dropped.

Decomposition:
- Shared package `timer_pkg`:
  - register offset constants: TMR_CTRL, TMR_COUNT, TMR_CMP, TMR_STATUS, TMR_PRESC;
  - CTRL bit indices;
  - response-FSM enum: RSP_OKAY, RSP_ERR1, RSP_ERR2.
- One sub-module, `timer_core`: prescaler, counter and compare logic, with a register write-strobe interface. `ahb_timer` keeps the AHB front-end and register file.

Test Plan:
- Reset, then read all 5 registers → each returns 0; `timer_irq_o` = 0; `hresp_o` = 0 on every read.
- Write PRESC = 0, CMP = 5, CTRL = 0x7 → PEND = 1 after 6 counting cycles; COUNT reads 0, 1, … restarting after the match; `timer_irq_o` = 1. Write STATUS = 1 → irq drops the next cycle.
- PRESC = 3, CMP = 2, CTRL = 0x3 (no autoreload) → COUNT increments every 4th cycle; match at COUNT = 2; COUNT continues to 3.
- COUNT = 0xFFFFFFFF, CMP = 0x10, PRESC = 0, EN = 1 → COUNT wraps to 0x0 with no PEND; PEND later sets at 0x10.
- Halfword write (hsize = 1) to CMP, and a word read at 0x06 → each gets one ERR1 cycle (hreadyout = 0, hresp = 1), then ERR2 (hreadyout = 1, hresp = 1); CMP unchanged.
- Write-1 to STATUS in the same cycle as a match → PEND remains 1. Bus write COUNT = 0x100 on a tick cycle → COUNT reads 0x100.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit positions and response-FSM encoding for the AHB timer.
package timer_pkg;

  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_COUNT  = 3'd1;
  localparam logic [2:0] TMR_CMP    = 3'd2;
  localparam logic [2:0] TMR_STATUS = 3'd3;
  localparam logic [2:0] TMR_PRESC  = 3'd4;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_AR = 2;

  typedef enum logic [1:0] {
    RSP_OKAY = 2'd0,
    RSP_ERR1 = 2'd1,
    RSP_ERR2 = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/ahb_timer_if.sv
// AHB-Lite slave-side bus bundle for the timer; clock and reset stay outside.
interface ahb_timer_if;
  logic        hsel_i;
  logic        hwrite_i;
  logic        hready_i;
  logic [2:0]  hsize_i;
  logic [2:0]  hburst_i;
  logic [1:0]  htrans_i;
  logic [31:0] hwdata_i;
  logic [31:0] haddr_i;
  logic        hreadyout_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;

  modport slave (
    input  hsel_i, hwrite_i, hready_i, hsize_i, hburst_i, htrans_i, hwdata_i, haddr_i,
    output hreadyout_o, hresp_o, hrdata_o
  );

  modport master (
    output hsel_i, hwrite_i, hready_i, hsize_i, hburst_i, htrans_i, hwdata_i, haddr_i,
    input  hreadyout_o, hresp_o, hrdata_o
  );
endinterface

// File: rtl/timer_core.sv
// Prescaler, 32-bit up-counter and compare-match pending flag, driven by register write strobes.
module timer_core #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_autoreload,
  input  logic [31:0]        i_cmp,
  input  logic [PRESC_W-1:0] i_presc,
  input  logic               i_presc_we,
  input  logic               i_count_we,
  input  logic               i_pend_clr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_count,
  output logic               o_pend
);

  logic [PRESC_W-1:0] r_pcnt;
  logic [31:0]        r_count;
  logic               r_pend;
  logic               w_tick;
  logic               w_match;

  assign w_tick  = i_en && (r_pcnt == i_presc);
  assign w_match = w_tick && (r_count == i_cmp);

  // A bus write to COUNT overrides the tick; a match set overrides a W1C clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt  <= '0;
      r_count <= '0;
      r_pend  <= 1'b0;
    end else begin
      if (!i_en || w_tick || i_presc_we) r_pcnt <= '0;
      else                               r_pcnt <= r_pcnt + 1'b1;

      if (i_count_we)                    r_count <= i_wdata;
      else if (w_match && i_autoreload)  r_count <= '0;
      else if (w_tick)                   r_count <= r_count + 32'd1;

      if (w_match)         r_pend <= 1'b1;
      else if (i_pend_clr) r_pend <= 1'b0;
    end
  end

  assign o_count = r_count;
  assign o_pend  = r_pend;

endmodule

// File: rtl/ahb_timer.sv
// AHB-Lite timer slave: bus front-end, CTRL/CMP/PRESC registers, two-cycle ERROR response.
module ahb_timer
  import timer_pkg::*;
#(
  parameter int PRESC_W    = 16,
  parameter int ADDR_LSB_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  ahb_timer_if.slave  bus,
  output logic        timer_irq_o
);

  logic                  w_accept;
  logic                  w_legal;
  logic [ADDR_LSB_W-3:0] w_idx;
  logic [31:0]           w_rd_val;
  logic [31:0]           w_count;
  logic                  w_pend;
  logic                  w_unused;

  rsp_state_e            r_state;
  logic                  r_dp_wr;
  logic [ADDR_LSB_W-3:0] r_idx;
  logic [31:0]           r_hrdata;
  logic [2:0]            r_ctrl;
  logic [31:0]           r_cmp;
  logic [PRESC_W-1:0]    r_presc;

  assign w_accept = bus.hsel_i && bus.hready_i && bus.htrans_i[1];
  assign w_legal  = (bus.hsize_i == 3'b010) && (bus.haddr_i[1:0] == 2'b00);
  assign w_idx    = bus.haddr_i[ADDR_LSB_W-1:2];
  assign w_unused = ^{bus.hburst_i, bus.htrans_i[0], bus.haddr_i[31:ADDR_LSB_W]};

  always_comb begin
    w_rd_val = '0;
    case (w_idx)
      TMR_CTRL:   w_rd_val = {29'd0, r_ctrl};
      TMR_COUNT:  w_rd_val = w_count;
      TMR_CMP:    w_rd_val = r_cmp;
      TMR_STATUS: w_rd_val = {31'd0, w_pend};
      TMR_PRESC:  w_rd_val = {{(32-PRESC_W){1'b0}}, r_presc};
      default:    w_rd_val = '0;
    endcase
  end

  // Address phase latches the transfer; legal writes commit at the end of the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RSP_OKAY;
      r_dp_wr  <= 1'b0;
      r_idx    <= '0;
      r_hrdata <= '0;
      r_ctrl   <= '0;
      r_cmp    <= '0;
      r_presc  <= '0;
    end else begin
      r_dp_wr <= w_accept && w_legal && bus.hwrite_i;
      if (w_accept) r_idx <= w_idx;
      if (w_accept && w_legal && !bus.hwrite_i) r_hrdata <= w_rd_val;

      case (r_state)
        RSP_OKAY: if (w_accept && !w_legal) r_state <= RSP_ERR1;
        RSP_ERR1: r_state <= RSP_ERR2;
        RSP_ERR2: r_state <= (w_accept && !w_legal) ? RSP_ERR1 : RSP_OKAY;
        default:  r_state <= RSP_OKAY;
      endcase

      if (r_dp_wr) begin
        case (r_idx)
          TMR_CTRL:  r_ctrl  <= bus.hwdata_i[2:0];
          TMR_CMP:   r_cmp   <= bus.hwdata_i;
          TMR_PRESC: r_presc <= bus.hwdata_i[PRESC_W-1:0];
          default:   ;
        endcase
      end
    end
  end

  timer_core #(.PRESC_W(PRESC_W)) u_core (
    .clk          (clk),
    .rst          (rst),
    .i_en         (r_ctrl[CTRL_EN]),
    .i_autoreload (r_ctrl[CTRL_AR]),
    .i_cmp        (r_cmp),
    .i_presc      (r_presc),
    .i_presc_we   (r_dp_wr && (r_idx == TMR_PRESC)),
    .i_count_we   (r_dp_wr && (r_idx == TMR_COUNT)),
    .i_pend_clr   (r_dp_wr && (r_idx == TMR_STATUS) && bus.hwdata_i[0]),
    .i_wdata      (bus.hwdata_i),
    .o_count      (w_count),
    .o_pend       (w_pend)
  );

  assign bus.hreadyout_o = (r_state != RSP_ERR1);
  assign bus.hresp_o     = (r_state != RSP_OKAY);
  assign bus.hrdata_o    = r_hrdata;
  assign timer_irq_o     = w_pend & r_ctrl[CTRL_IE];

endmodule

// File: tb/tb_ahb_timer.sv
// Scoreboard bench for ahb_timer: a cycle-level register model predicts every response.
module tb_ahb_timer;

  logic clk = 1'b0;
  logic rst;
  logic irq;
  logic active = 1'b0;

  ahb_timer_if bus();

  always #5 clk = ~clk;
  assign bus.hready_i = bus.hreadyout_o;

  ahb_timer #(.PRESC_W(16), .ADDR_LSB_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .timer_irq_o (irq)
  );

  typedef struct packed {
    logic        legal;
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: architectural register state for the current cycle.
  logic        m_en = 0, m_ie = 0, m_ar = 0, m_pend = 0;
  logic [31:0] m_count = 0, m_cmp = 0;
  logic [15:0] m_presc = 0, m_pcnt = 0;
  logic        d_valid = 0, d_wr = 0, d_legal = 0;
  logic [2:0]  d_idx = 0;
  logic [31:0] dp_wdata = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic h_rdy, output logic acc);
    logic        legal, tick, set, clr;
    logic [31:0] rd, n_count;
    logic [15:0] n_pcnt;
    acc   = bus.hsel_i && h_rdy && bus.htrans_i[1];
    legal = (bus.hsize_i == 3'd2) && (bus.haddr_i[1:0] == 2'b00);
    case (bus.haddr_i[4:2])
      3'd0:    rd = {29'd0, m_ar, m_ie, m_en};
      3'd1:    rd = m_count;
      3'd2:    rd = m_cmp;
      3'd3:    rd = {31'd0, m_pend};
      3'd4:    rd = {16'd0, m_presc};
      default: rd = 32'd0;
    endcase
    if (acc) sb.push_back('{legal, bus.hwrite_i, rd});
    tick    = m_en && (m_pcnt == m_presc);
    set     = tick && (m_count == m_cmp);
    n_pcnt  = (m_en && !tick) ? m_pcnt + 16'd1 : 16'd0;
    n_count = !tick ? m_count : ((set && m_ar) ? 32'd0 : m_count + 32'd1);
    clr     = 1'b0;
    if (d_valid && d_wr && d_legal) begin
      case (d_idx)
        3'd0: {m_ar, m_ie, m_en} = bus.hwdata_i[2:0];
        3'd1: n_count = bus.hwdata_i;
        3'd2: m_cmp = bus.hwdata_i;
        3'd3: clr = bus.hwdata_i[0];
        3'd4: begin m_presc = bus.hwdata_i[15:0]; n_pcnt = 16'd0; end
        default: ;
      endcase
    end
    m_pend  = set || (m_pend && !clr);
    m_count = n_count;
    m_pcnt  = n_pcnt;
    d_valid = acc;
    d_wr    = bus.hwrite_i;
    d_legal = legal;
    d_idx   = bus.haddr_i[4:2];
  endtask

  task automatic bus_cycle(input logic sel, input logic wr, input logic [1:0] tr,
                           input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, output logic acc);
    logic h_rdy;
    bus.hsel_i   = sel;
    bus.hwrite_i = wr;
    bus.htrans_i = tr;
    bus.hsize_i  = sz;
    bus.haddr_i  = addr;
    bus.hburst_i = 3'($urandom);
    bus.hwdata_i = dp_wdata;
    h_rdy = bus.hreadyout_o;
    @(posedge clk);
    model_edge(h_rdy, acc);
    if (acc && wr) dp_wdata = wd;
    #1;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wd);
    logic acc;
    int   n = 0;
    do begin
      bus_cycle(1'b1, wr, 2'b10, sz, addr, wd, acc);
      n++;
    end while (!acc && n < 8);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] wd);
    xfer(1'b1, addr, 3'd2, wd);
  endtask

  task automatic rd32(input logic [31:0] addr);
    xfer(1'b0, addr, 3'd2, 32'd0);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 2'b00, 3'd0, 32'd0, 32'd0, acc);
  endtask

  // Monitor: pops one expectation per data phase and checks the response.
  logic mdp = 0, merr2 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst || !active) begin
      mdp   = 0;
      merr2 = 0;
    end else begin
      if (merr2) begin
        chk("err2_hreadyout", {31'd0, bus.hreadyout_o}, 32'd1);
        chk("err2_hresp", {31'd0, bus.hresp_o}, 32'd1);
        merr2 = 0;
      end else if (mdp) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          if (!e.legal) begin
            chk("err1_hreadyout", {31'd0, bus.hreadyout_o}, 32'd0);
            chk("err1_hresp", {31'd0, bus.hresp_o}, 32'd1);
            merr2 = 1;
          end else begin
            chk("ok_hreadyout", {31'd0, bus.hreadyout_o}, 32'd1);
            chk("ok_hresp", {31'd0, bus.hresp_o}, 32'd0);
            if (!e.wr) chk("rdata", bus.hrdata_o, e.rdata);
          end
        end
      end else begin
        chk("idle_hresp", {31'd0, bus.hresp_o}, 32'd0);
      end
      chk("irq", {31'd0, irq}, {31'd0, m_pend & m_ie});
      mdp = bus.hsel_i && bus.hreadyout_o && bus.htrans_i[1];
    end
  end

  initial begin
    rst          = 1'b1;
    bus.hsel_i   = 0;
    bus.hwrite_i = 0;
    bus.htrans_i = 0;
    bus.hsize_i  = 0;
    bus.hburst_i = 0;
    bus.haddr_i  = 0;
    bus.hwdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hreadyout", {31'd0, bus.hreadyout_o}, 32'd1);
    chk("rst_hresp", {31'd0, bus.hresp_o}, 32'd0);
    chk("rst_hrdata", bus.hrdata_o, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst    = 1'b0;
    active = 1'b1;

    for (int i = 0; i < 8; i++) rd32(32'(i * 4));
    idle(1);

    // Autoreload match every 6 ticks, then W1C
    wr32(32'h10, 32'd0);
    wr32(32'h08, 32'd5);
    wr32(32'h00, 32'd7);
    for (int i = 0; i < 16; i++) rd32(32'h04);
    rd32(32'h0C);
    wr32(32'h0C, 32'd1);
    idle(3);

    // Prescaled, no autoreload
    wr32(32'h00, 32'd0);
    wr32(32'h04, 32'd0);
    wr32(32'h0C, 32'd1);
    wr32(32'h10, 32'd3);
    wr32(32'h08, 32'd2);
    wr32(32'h00, 32'd3);
    for (int i = 0; i < 20; i++) begin rd32(32'h04); rd32(32'h0C); end

    // Wrap through zero
    wr32(32'h00, 32'd0);
    wr32(32'h0C, 32'd1);
    wr32(32'h04, 32'hFFFF_FFFF);
    wr32(32'h08, 32'h10);
    wr32(32'h10, 32'd0);
    wr32(32'h00, 32'd1);
    for (int i = 0; i < 14; i++) begin rd32(32'h04); rd32(32'h0C); end

    // Illegal transfers, including back-to-back
    xfer(1'b1, 32'h08, 3'd1, 32'hDEAD_BEEF);
    rd32(32'h08);
    xfer(1'b0, 32'h06, 3'd2, 32'd0);
    xfer(1'b0, 32'h05, 3'd2, 32'd0);
    xfer(1'b1, 32'h08, 3'd0, 32'h1234);
    rd32(32'h08);
    idle(2);

    // W1C colliding with match, swept over offsets; COUNT write on tick
    for (int off = 0; off < 8; off++) begin
      wr32(32'h00, 32'd0);
      wr32(32'h0C, 32'd1);
      wr32(32'h10, 32'd0);
      wr32(32'h08, 32'd3);
      wr32(32'h04, 32'd0);
      wr32(32'h00, 32'd1);
      idle(off);
      wr32(32'h0C, 32'd1);
      rd32(32'h0C);
    end
    wr32(32'h04, 32'h100);
    wr32(32'h00, 32'd0);
    rd32(32'h04);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int          k;
      logic [2:0]  idx;
      logic [31:0] addr, wd;
      logic [2:0]  sz;
      logic        acc;
      k = $urandom_range(0, 9);
      if (k == 0) begin
        idle($urandom_range(1, 3));
      end else if (k == 1) begin
        bus_cycle(1'b1, 1'($urandom), {1'b0, 1'($urandom)}, 3'd2,
                  32'($urandom_range(0, 7) * 4), $urandom, acc);
      end else begin
        idx  = 3'($urandom_range(0, 7));
        addr = 32'h4000_0000 | {27'd0, idx, 2'b00};
        if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom);
        sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
        case (idx)
          3'd1:    wd = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 8));
          3'd2:    wd = 32'($urandom_range(0, 8));
          3'd4:    wd = 32'($urandom_range(0, 3));
          default: wd = $urandom;
        endcase
        xfer(1'($urandom), addr, sz, wd);
      end
    end

    idle(4);
    active = 1'b0;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
